// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
// booth_ctrl : sequencer for a radix-2 Booth multiplier datapath (A, Q, M, Q-1)
// Optional feature: define BOOTH_STAT_EN to add the op_cnt add/sub counter.
// Revision: 1.0
// ============================================================================
module booth_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  output logic ldM,
  output logic ldQ,
  output logic clrQ,
  output logic sftQ,
  output logic ldA,
  output logic clrA,
  output logic sftA,
  output logic clrFF,
  output logic sftFF,
  output logic addsub,
  output logic busy,
  output logic done
`ifdef BOOTH_STAT_EN
  ,
  output logic [CNT_W-1:0] op_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DECIDE = 3'd2,
    S_ADDSUB = 3'd3,
    S_SHIFT  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only qm1 of the decided pair is kept: 01 selects add, 10 selects subtract.
  logic             op_q, op_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ldM     = 1'b0;
    ldQ     = 1'b0;
    clrQ    = 1'b0;
    sftQ    = 1'b0;
    ldA     = 1'b0;
    clrA    = 1'b0;
    sftA    = 1'b0;
    clrFF   = 1'b0;
    sftFF   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ldM     = 1'b1;
        ldQ     = 1'b1;
        clrA    = 1'b1;
        clrFF   = 1'b1;
        cnt_d   = CNT_W'(WIDTH);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (q0 ^ qm1) begin
          op_d    = qm1;
          state_d = S_ADDSUB;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADDSUB: begin
        ldA     = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sftA    = 1'b1;
        sftQ    = 1'b1;
        sftFF   = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_DECIDE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addsub = op_q;
  assign busy   = (state_q != S_IDLE);

`ifdef BOOTH_STAT_EN
  logic [CNT_W-1:0] op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if (state_q == S_LOAD) begin
      op_cnt_q <= '0;
    end else if ((state_q == S_DECIDE) && (q0 ^ qm1)) begin
      op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`default_nettype none
// ============================================================================
// tb_booth_ctrl : randomized bench with a behavioural Booth datapath and model.
// Revision: 1.0
// ============================================================================
module tb_booth_ctrl;

  localparam int W = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic q0, qm1;
  logic ldM, ldQ, clrQ, sftQ, ldA, clrA, sftA, clrFF, sftFF, addsub, busy, done;
`ifdef BOOTH_STAT_EN
  logic [CW-1:0] op_cnt;
`endif

  int checks = 0;
  int errors = 0;

  booth_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .qm1(qm1),
    .ldM(ldM), .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ), .ldA(ldA), .clrA(clrA),
    .sftA(sftA), .clrFF(clrFF), .sftFF(sftFF), .addsub(addsub),
    .busy(busy), .done(done)
`ifdef BOOTH_STAT_EN
    , .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [11:0] outs;
  assign outs = {ldM, ldQ, clrQ, sftQ, ldA, clrA, sftA, clrFF, sftFF, addsub, busy, done};

  // Behavioural datapath: registers capture on the falling edge, clr > ld > sft.
  logic [W-1:0] dp_a = '0, dp_q = '0, dp_m = '0, dp_min = '0, dp_qin = '0;
  logic         dp_f = 1'b0;
  assign q0  = dp_q[0];
  assign qm1 = dp_f;

  always @(negedge clk) begin : dp
    logic [W-1:0] a_n, q_n, m_n;
    logic f_n;
    a_n = dp_a; q_n = dp_q; m_n = dp_m; f_n = dp_f;
    if (clrA)      a_n = '0;
    else if (ldA)  a_n = addsub ? dp_a + dp_m : dp_a - dp_m;
    else if (sftA) a_n = {dp_a[W-1], dp_a[W-1:1]};
    if (clrQ)      q_n = '0;
    else if (ldQ)  q_n = dp_qin;
    else if (sftQ) q_n = {dp_a[0], dp_q[W-1:1]};
    if (ldM)       m_n = dp_min;
    if (clrFF)      f_n = 1'b0;
    else if (sftFF) f_n = dp_q[0];
    dp_a = a_n; dp_q = q_n; dp_m = m_n; dp_f = f_n;
  end

  function automatic logic [W-1:0] rand_m();
    logic [W-1:0] v;
    v = W'($urandom);
    if (v == 16'h8000) v = 16'h7FFF;
    return v;
  endfunction

  // One multiply: launched=1 means LOAD is the current cycle already; hold keeps
  // start high through DONE; poke pulses start while busy.
  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] qv,
                          input bit launched, input bit hold, input bit poke,
                          input string name);
    bit exp_ops[$];
    bit obs_ops[$];
    bit prev, got, seq_ok;
    int n_exp, exp_done, cyc, done_cyc;
    int n_ldm, n_lda, n_sfta, n_sftq, n_sftff, busy_bad, excl_bad, load_bad;
    logic [2*W-1:0] exp_p, got_p;

    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (qv[i] && !prev) exp_ops.push_back(1'b0);
      else if (!qv[i] && prev) exp_ops.push_back(1'b1);
      prev = qv[i];
    end
    n_exp    = exp_ops.size();
    exp_done = 2 + 2 * W + n_exp;
    exp_p    = {{W{m[W-1]}}, m} * {{W{qv[W-1]}}, qv};

    dp_min = m;
    dp_qin = qv;
    if (!launched) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold) start = 1'b0;

    cyc = 1; got = 0;
    n_ldm = 0; n_lda = 0; n_sfta = 0; n_sftq = 0; n_sftff = 0;
    busy_bad = 0; excl_bad = 0; load_bad = 0;
    while (cyc <= 80) begin
      if (ldM) n_ldm++;
      if (ldA) begin n_lda++; obs_ops.push_back(addsub); end
      if (sftA) n_sfta++;
      if (sftQ) n_sftq++;
      if (sftFF) n_sftff++;
      if (cyc == 1 && !(ldM && ldQ && clrA && clrFF)) load_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (int'(clrA) + int'(ldA) + int'(sftA) > 1) excl_bad++;
      if (int'(clrQ) + int'(ldQ) + int'(sftQ) > 1) excl_bad++;
      if (int'(clrFF) + int'(sftFF) > 1) excl_bad++;
      if (done === 1'b1) begin got = 1; break; end
      if (poke && !hold) start = (cyc >= 3 && cyc <= 20 && (cyc % 4) == 3);
      @(posedge clk); #1;
      cyc++;
    end
    if (!hold) start = 1'b0;
    done_cyc = got ? cyc : -1;
    got_p = {dp_a, dp_q};

    checks++;
    if (done_cyc !== exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (n_sfta != W || n_sftq != W || n_sftff != W) begin
      errors++;
      $display("FAIL %s shift_pulses: got A=%0d Q=%0d FF=%0d expected %0d each",
               name, n_sfta, n_sftq, n_sftff, W);
    end
    checks++;
    if (n_lda != n_exp) begin
      errors++;
      $display("FAIL %s ldA_pulses: got %0d expected %0d", name, n_lda, n_exp);
    end
    checks++;
    seq_ok = (obs_ops.size() == exp_ops.size());
    if (seq_ok) foreach (exp_ops[i]) if (obs_ops[i] !== exp_ops[i]) seq_ok = 0;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s addsub_seq: got %p expected %p", name, obs_ops, exp_ops);
    end
    checks++;
    if (n_ldm != 1 || load_bad != 0) begin
      errors++;
      $display("FAIL %s load_strobes: got ldM pulses %0d bad load %0d expected 1 and 0",
               name, n_ldm, load_bad);
    end
    checks++;
    if (busy_bad != 0 || excl_bad != 0) begin
      errors++;
      $display("FAIL %s busy_excl: got busy low %0d excl %0d expected 0 and 0",
               name, busy_bad, excl_bad);
    end
    checks++;
    if (got_p !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", name, got_p, exp_p);
    end
`ifdef BOOTH_STAT_EN
    checks++;
    if (op_cnt !== CW'(n_exp)) begin
      errors++;
      $display("FAIL %s op_cnt: got %0d expected %0d", name, op_cnt, n_exp);
    end
`endif

    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
    if (hold) begin
      @(posedge clk); #1;
      checks++;
      if (ldM !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s restart_load: got ldM=%b busy=%b expected 1 1", name, ldM, busy);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", outs);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 000", outs);
    end
`ifdef BOOTH_STAT_EN
    checks++;
    if (op_cnt !== '0) begin
      errors++;
      $display("FAIL reset_op_cnt: got %0d expected 0", op_cnt);
    end
`endif
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_patterns();
    run_mult(rand_m(), 16'h0000, 0, 0, 0, "q0000");
    run_mult(rand_m(), 16'h0001, 0, 0, 0, "q0001");
    run_mult(rand_m(), 16'hFFFF, 0, 0, 0, "qFFFF");
    run_mult(rand_m(), 16'h5555, 0, 0, 0, "q5555");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_mult(rand_m(), W'($urandom), 0, 0, 0, "random");
  endtask

  task automatic test_start_while_busy();
    run_mult(rand_m(), 16'hA5C3, 0, 0, 1, "poke_busy");
  endtask

  task automatic test_back_to_back();
    run_mult(rand_m(), W'($urandom), 0, 1, 0, "b2b_first");
    run_mult(rand_m(), W'($urandom), 1, 0, 0, "b2b_second");
  endtask

  task automatic test_reset_midrun();
    int nsft;
    bit reached;
    dp_min = rand_m();
    dp_qin = W'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nsft = 0; reached = 0;
    for (int c = 0; c < 60; c++) begin
      if (sftA) nsft++;
      if (nsft == 5) begin reached = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midrun_reach: got %0d shifts expected 5", nsft);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h expected 000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: got busy=%b expected 0", busy);
    end
    run_mult(rand_m(), W'($urandom), 0, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
